addr_decoder_cfg_loader: RTL and testbench

//   Frame parser and write sequencer upstream of the decoder config store.

---
 rtl/addr_decoder_cfg_loader_if.sv | 19 +
 rtl/addr_decoder_cfg_loader.sv | 160 ++++++++++++++++
 tb/tb_addr_decoder_cfg_loader.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/addr_decoder_cfg_loader_if.sv
// Byte stream handshake into the config loader.
// A beat is s_valid & s_ready.
interface addr_decoder_cfg_loader_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/addr_decoder_cfg_loader.sv
// Frame parser [ADDR][LEN][DATA x LEN] -> single-cycle config writes.
// Range check, write lock, frame timeout, sticky errors.
module addr_decoder_cfg_loader #(
  parameter int ADDR_W  = 32,
  parameter int NUM_WIN = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                         cfg_clk,
  input  logic                         cfg_rst_n,
  addr_decoder_cfg_loader_if.slave     s,
  input  logic                         cfg_lock,
  input  logic                         err_clr,
  output logic                         cfg_we,
  output logic [7:0]                   cfg_addr,
  output logic [7:0]                   cfg_wdata,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         err_range,
  output logic                         err_lock,
  output logic                         err_timeout
);

  localparam int CFG_BYTES = (ADDR_W + 7) / 8;
  localparam int CFG_SIZE  = NUM_WIN * (2 * CFG_BYTES + 2);
  localparam logic [8:0]  SIZE9 = 9'(CFG_SIZE);
  localparam logic [15:0] TO_M1 = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [8:0]  ptr, ptr_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [15:0] idle, idle_nxt;
  logic        we_nxt;
  logic [7:0]  addr_nxt;
  logic [7:0]  wdata_nxt;
  logic        done_nxt;
  logic        set_range;
  logic        set_lock;
  logic        set_to;
  logic        beat;
  logic        rdy;

  assign s.s_ready = rdy;
  assign beat      = s.s_valid & rdy;
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
    if (!cfg_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state, write generation, error events and idle timeout
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    idle_nxt  = idle;
    we_nxt    = 1'b0;
    addr_nxt  = cfg_addr;
    wdata_nxt = cfg_wdata;
    done_nxt  = 1'b0;
    set_range = 1'b0;
    set_lock  = 1'b0;
    set_to    = 1'b0;
    unique case (state)
      IDLE: begin
        idle_nxt = '0;
        if (beat) begin
          ptr_nxt   = {1'b0, s.s_data};
          state_nxt = LEN;
        end
      end
      LEN: begin
        if (beat) begin
          idle_nxt = '0;
          if (s.s_data != 8'd0) begin
            cnt_nxt   = s.s_data;
            state_nxt = DATA;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      DATA: begin
        if (beat) begin
          idle_nxt = '0;
          unique case (1'b1)
            (ptr >= SIZE9): set_range = 1'b1;
            cfg_lock:       set_lock  = 1'b1;
            default: begin
              we_nxt    = 1'b1;
              addr_nxt  = ptr[7:0];
              wdata_nxt = s.s_data;
            end
          endcase
          ptr_nxt = ptr + 9'd1;
          cnt_nxt = cnt - 8'd1;
          if (cnt == 8'd1) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && !beat) begin
      if (idle == TO_M1) begin
        state_nxt = IDLE;
        idle_nxt  = '0;
        set_to    = 1'b1;
      end else begin
        idle_nxt = idle + 16'd1;
      end
    end
  end

  // Datapath registers, write strobe and frame pulse
  always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
    if (!cfg_rst_n) begin
      rdy        <= 1'b0;
      ptr        <= '0;
      cnt        <= '0;
      idle       <= '0;
      cfg_we     <= 1'b0;
      cfg_addr   <= '0;
      cfg_wdata  <= '0;
      frame_done <= 1'b0;
    end else begin
      rdy        <= 1'b1;
      ptr        <= ptr_nxt;
      cnt        <= cnt_nxt;
      idle       <= idle_nxt;
      cfg_we     <= we_nxt;
      cfg_addr   <= addr_nxt;
      cfg_wdata  <= wdata_nxt;
      frame_done <= done_nxt;
    end
  end

  // Sticky error flags; a set event beats a clear
  always_ff @(posedge cfg_clk or negedge cfg_rst_n) begin
    if (!cfg_rst_n) begin
      err_range   <= 1'b0;
      err_lock    <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_range   <= (err_range & ~err_clr) | set_range;
      err_lock    <= (err_lock & ~err_clr) | set_lock;
      err_timeout <= (err_timeout & ~err_clr) | set_to;
    end
  end

endmodule

// File: tb/tb_addr_decoder_cfg_loader.sv
// Directed bench for addr_decoder_cfg_loader.
// Vector table plus timeout, gap and reset sequences.
module tb_addr_decoder_cfg_loader;

  logic       clk;
  logic       rst_n;
  logic       cfg_lock;
  logic       err_clr;
  logic       cfg_we;
  logic [7:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       busy;
  logic       frame_done;
  logic       err_range;
  logic       err_lock;
  logic       err_timeout;

  addr_decoder_cfg_loader_if bus ();

  addr_decoder_cfg_loader dut (
    .cfg_clk     (clk),
    .cfg_rst_n   (rst_n),
    .s           (bus.slave),
    .cfg_lock    (cfg_lock),
    .err_clr     (err_clr),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .busy        (busy),
    .frame_done  (frame_done),
    .err_range   (err_range),
    .err_lock    (err_lock),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc++;

  int n_chk;
  int n_pass;

  logic [7:0] wa_q[$];
  logic [7:0] wd_q[$];
  int         wc_q[$];
  int         dn_q[$];

  // Record writes and frame pulses away from the active edge
  always @(negedge clk) begin
    if (cfg_we) begin
      wa_q.push_back(cfg_addr);
      wd_q.push_back(cfg_wdata);
      wc_q.push_back(cyc);
    end
    if (frame_done) dn_q.push_back(cyc);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic clr_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    dn_q.delete();
  endtask

  // Called at a negedge; returns at the next negedge
  task automatic send(input logic [7:0] b);
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] fr[8];
    int         n;
    logic       lock;
    int         nw;
    logic [7:0] ea[4];
    logic [7:0] ed[4];
    logic       er;
    logic       el;
  } vec_t;

  vec_t vt[6];

  logic [7:0] gfr[6];
  logic [7:0] gea[4];
  logic [7:0] ged[4];

  initial begin
    vt[0] = '{'{8'h05, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00},
              5, 1'b0, 3,
              '{8'h05, 8'h06, 8'h07, 8'h00},
              '{8'hAA, 8'hBB, 8'hCC, 8'h00}, 1'b0, 1'b0};
    vt[1] = '{'{8'h9E, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00},
              6, 1'b0, 2,
              '{8'h9E, 8'h9F, 8'h00, 8'h00},
              '{8'h11, 8'h22, 8'h00, 8'h00}, 1'b1, 1'b0};
    vt[2] = '{'{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
              2, 1'b0, 0,
              '{8'h00, 8'h00, 8'h00, 8'h00},
              '{8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0};
    vt[3] = '{'{8'h20, 8'h01, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
              3, 1'b1, 0,
              '{8'h00, 8'h00, 8'h00, 8'h00},
              '{8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1};
    vt[4] = '{'{8'hFF, 8'h02, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00},
              4, 1'b0, 0,
              '{8'h00, 8'h00, 8'h00, 8'h00},
              '{8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0};
    vt[5] = '{'{8'h00, 8'h02, 8'hE1, 8'hE2, 8'h00, 8'h00, 8'h00, 8'h00},
              4, 1'b0, 2,
              '{8'h00, 8'h01, 8'h00, 8'h00},
              '{8'hE1, 8'hE2, 8'h00, 8'h00}, 1'b0, 1'b0};

    gfr = '{8'h40, 8'h04, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
    gea = '{8'h40, 8'h41, 8'h42, 8'h43};
    ged = '{8'hD1, 8'hD2, 8'hD3, 8'hD4};

    n_chk       = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    cfg_lock    = 1'b0;
    err_clr     = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_we",    32'(cfg_we),      32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_flags", 32'({err_range, err_lock, err_timeout, frame_done}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_up", 32'(bus.s_ready), 32'd1);
    clr_log();

    // Table-driven frames, back-to-back beats
    for (int v = 0; v < 6; v++) begin
      clr_log();
      cfg_lock = vt[v].lock;
      for (int i = 0; i < vt[v].n; i++) send(vt[v].fr[i]);
      idle(3);
      cfg_lock = 1'b0;
      chk($sformatf("v%0d_nw", v), 32'(wa_q.size()), 32'(vt[v].nw));
      if (wa_q.size() == vt[v].nw) begin
        for (int i = 0; i < vt[v].nw; i++) begin
          chk($sformatf("v%0d_a%0d", v, i), 32'(wa_q[i]), 32'(vt[v].ea[i]));
          chk($sformatf("v%0d_d%0d", v, i), 32'(wd_q[i]), 32'(vt[v].ed[i]));
          if (i > 0)
            chk($sformatf("v%0d_b2b%0d", v, i), 32'(wc_q[i] - wc_q[i-1]), 32'd1);
        end
      end
      chk($sformatf("v%0d_done", v), 32'(dn_q.size()), 32'd1);
      if (vt[v].nw > 0 && wc_q.size() > 0 && dn_q.size() > 0 && !vt[v].er)
        chk($sformatf("v%0d_done_t", v), 32'(dn_q[0]), 32'(wc_q[wc_q.size()-1]));
      chk($sformatf("v%0d_busy", v), 32'(busy), 32'd0);
      chk($sformatf("v%0d_erng", v), 32'(err_range), 32'(vt[v].er));
      chk($sformatf("v%0d_elck", v), 32'(err_lock), 32'(vt[v].el));
      chk($sformatf("v%0d_eto", v), 32'(err_timeout), 32'd0);
      pulse_clr();
      chk($sformatf("v%0d_clr", v), 32'({err_range, err_lock, err_timeout}), 32'd0);
    end

    // Zero-length frame: pulse one cycle after the LEN beat
    clr_log();
    send(8'h10);
    send(8'h00);
    chk("len0_pulse", 32'(frame_done), 32'd1);
    chk("len0_busy", 32'(busy), 32'd0);
    idle(1);
    chk("len0_drop", 32'(frame_done), 32'd0);

    // Timeout mid-frame
    clr_log();
    send(8'h30);
    send(8'h02);
    send(8'h01);
    idle(1000);
    chk("to_busy_pre", 32'(busy), 32'd1);
    chk("to_flag_pre", 32'(err_timeout), 32'd0);
    idle(30);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_flag", 32'(err_timeout), 32'd1);
    chk("to_nodone", 32'(dn_q.size()), 32'd0);
    chk("to_nw", 32'(wa_q.size()), 32'd1);
    clr_log();
    send(8'h31);
    send(8'h01);
    send(8'h7F);
    idle(2);
    chk("to_next_nw", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1) begin
      chk("to_next_a", 32'(wa_q[0]), 32'h31);
      chk("to_next_d", 32'(wd_q[0]), 32'h7F);
    end
    chk("to_sticky", 32'(err_timeout), 32'd1);
    pulse_clr();
    chk("to_clr", 32'(err_timeout), 32'd0);

    // Random gaps between beats
    clr_log();
    for (int i = 0; i < 6; i++) begin
      idle($urandom_range(0, 5));
      send(gfr[i]);
    end
    idle(3);
    chk("gap_nw", 32'(wa_q.size()), 32'd4);
    if (wa_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("gap_a%0d", i), 32'(wa_q[i]), 32'(gea[i]));
        chk($sformatf("gap_d%0d", i), 32'(wd_q[i]), 32'(ged[i]));
      end
    end
    chk("gap_done", 32'(dn_q.size()), 32'd1);
    chk("gap_noto", 32'(err_timeout), 32'd0);

    // Reset mid-DATA
    clr_log();
    send(8'h50);
    send(8'h05);
    send(8'h01);
    send(8'h02);
    chk("rmid_we_pre", 32'(cfg_we), 32'd1);
    bus.s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_we", 32'(cfg_we), 32'd0);
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_ready", 32'(bus.s_ready), 32'd0);
    chk("rmid_addr", 32'({cfg_addr, cfg_wdata}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clr_log();
    send(8'h60);
    send(8'h01);
    send(8'h77);
    idle(2);
    chk("rmid_nw", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() == 1) begin
      chk("rmid_a", 32'(wa_q[0]), 32'h60);
      chk("rmid_d", 32'(wd_q[0]), 32'h77);
    end
    chk("rmid_done", 32'(dn_q.size()), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
